// File: rtl/pump_ctrl.sv
// Irrigation pump controller: debounces the soil class, then runs the pump
// through IDLE -> RUN -> COOL with minimum/maximum run and forced cool-down.
module pump_ctrl #(
    parameter int DEBOUNCE = 4,
    parameter int MIN_ON   = 16,
    parameter int MAX_ON   = 64,
    parameter int COOLDOWN = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  class_in,
    input  logic        enable,
    output logic        pump_on,
    output logic [1:0]  state,
    output logic        timeout,
    output logic [15:0] run_count
);

    localparam logic [1:0] DRY     = 2'b00;
    localparam logic [1:0] OPTIMAL = 2'b01;
    localparam logic [1:0] INVALID = 2'b11;

    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam int ON_W = (MAX_ON > 1) ? $clog2(MAX_ON) : 1;
    localparam int CL_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [ON_W-1:0] ON_LAST = ON_W'(MAX_ON - 1);
    localparam logic [ON_W-1:0] ON_MIN  = ON_W'(MIN_ON - 1);
    localparam logic [CL_W-1:0] CL_LAST = CL_W'(COOLDOWN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        COOL = 2'b10
    } state_t;

    state_t          st;
    logic [1:0]      cand;
    logic [DB_W-1:0] db_cnt;
    logic [1:0]      class_stable;
    logic [ON_W-1:0] on_cnt;
    logic [CL_W-1:0] cool_cnt;

    assign state = st;

    // db_cnt is the number of consecutive identical valid samples seen so far,
    // so the DEBOUNCE-th matching sample is the one that updates class_stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand         <= OPTIMAL;
            db_cnt       <= '0;
            class_stable <= OPTIMAL;
        end else begin
            cand <= class_in;
            if (class_in == INVALID) begin
                db_cnt <= '0;
            end else if (class_in == cand) begin
                if (db_cnt != DB_MAX)
                    db_cnt <= db_cnt + 1'b1;
                if (db_cnt == DB_LAST)
                    class_stable <= class_in;
            end else begin
                db_cnt <= DB_ONE;
                if (DEBOUNCE == 1)
                    class_stable <= class_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            pump_on   <= 1'b0;
            timeout   <= 1'b0;
            run_count <= '0;
            on_cnt    <= '0;
            cool_cnt  <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (enable && class_stable == DRY) begin
                        st      <= RUN;
                        pump_on <= 1'b1;
                        on_cnt  <= '0;
                        if (run_count != 16'hFFFF)
                            run_count <= run_count + 16'd1;
                    end
                end
                RUN: begin
                    // Exit priority: enable drop, then MAX_ON, then class after MIN_ON.
                    if (!enable) begin
                        st       <= COOL;
                        pump_on  <= 1'b0;
                        cool_cnt <= '0;
                    end else if (on_cnt == ON_LAST) begin
                        st       <= COOL;
                        pump_on  <= 1'b0;
                        cool_cnt <= '0;
                        timeout  <= 1'b1;
                    end else if (on_cnt >= ON_MIN && class_stable != DRY) begin
                        st       <= COOL;
                        pump_on  <= 1'b0;
                        cool_cnt <= '0;
                    end else begin
                        on_cnt <= on_cnt + 1'b1;
                    end
                end
                COOL: begin
                    if (cool_cnt == CL_LAST)
                        st <= IDLE;
                    else
                        cool_cnt <= cool_cnt + 1'b1;
                end
                default: begin
                    st      <= IDLE;
                    pump_on <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pump_ctrl.md
PUMP_CTRL -- requirements
Module: pump_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state updates on the rising edge of clk.
REQ-002 The block SHALL have these parameters:
- DEBOUNCE, default 4: consecutive identical samples needed to accept a class change.
- MIN_ON, default 16: minimum pump run, in cycles.
- MAX_ON, default 64: maximum pump run, in cycles.
- COOLDOWN, default 32: forced pump-off interval after every run, in cycles.
REQ-003 The block SHALL have these ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- class_in  input  2  soil class from the classifier: 00 DRY, 01 OPTIMAL, 10 WET, 11 invalid.
- enable  input  1  global irrigation enable.
- pump_on  output  1  registered pump drive.
- state  output  2  FSM state: 00 IDLE, 01 RUN, 10 COOL.
- timeout  output  1  sticky flag, set when a run is ended by MAX_ON.
- run_count  output  16  number of runs started, saturating.

Function
REQ-004 Debounce: a candidate register samples class_in every cycle, and a counter counts consecutive edges with an unchanged sample.
REQ-005 class_stable SHALL take the candidate value on the edge where the counter reaches DEBOUNCE.
REQ-006 Invalid class 11 SHALL never be accepted; class_stable holds its previous value and the counter restarts.
REQ-007 IDLE: pump_on=0. Go to RUN on the edge where enable=1 and class_stable=DRY, clearing on_cnt to 0.
REQ-008 RUN: pump_on=1, and on_cnt increments every cycle.
REQ-009 RUN exit priority, highest first:
- (a) enable=0: go to COOL on the next edge, overriding MIN_ON.
- (b) on_cnt==MAX_ON-1: go to COOL and set timeout.
- (c) on_cnt>=MIN_ON-1 and class_stable!=DRY: go to COOL.
REQ-010 COOL: pump_on=0. cool_cnt is cleared on entry and increments each cycle. Go to IDLE on the edge where cool_cnt==COOLDOWN-1, regardless of enable or class.
REQ-011 pump_on SHALL be a registered output equal to (state==RUN), with no combinational path from any input.
REQ-012 The pump SHALL stay high for exactly MAX_ON cycles on a timeout run. It SHALL stay high for at least MIN_ON cycles on any run that enable does not end.
REQ-013 If the class returns to DRY within MIN_ON, the run SHALL continue without restarting on_cnt.
REQ-014 run_count SHALL increment by 1 on each IDLE->RUN transition and saturate at 16'hFFFF.
REQ-015 timeout SHALL stay set until rst; later runs SHALL NOT clear it.
REQ-016 Latency: DRY applied before edge 1 and held gives class_stable=DRY after edge 4 (DEBOUNCE) and pump_on=1 after edge 5.
REQ-017 Counter widths SHALL hold MAX_ON-1 and COOLDOWN-1 without wrap.
REQ-018 Parameter precondition: 1 <= MIN_ON <= MAX_ON.

Reset
REQ-019 While rst=1 the block SHALL reset, on the next edge:
- state=IDLE, pump_on=0, timeout=0, run_count=0.
- on_cnt=0, cool_cnt=0.
- class_stable=OPTIMAL, debounce counter=0.
REQ-020 Reset asserted during RUN SHALL drop pump_on on that same edge, with no COOL phase.
REQ-021 The first run after reset SHALL require a full debounce of DRY.

Verification
REQ-022 Drive class_in=00 and enable=1 from reset release -> pump_on rises after edge 5, run_count=1.
REQ-023 DRY for 5 cycles then WET held -> pump_on high exactly 16 cycles, then 32 cycles low, then state=IDLE with no new run.
REQ-024 DRY held permanently -> pump high 64 cycles, timeout=1, 32 cycles COOL, then a new run starts with run_count=2 and timeout still 1.
REQ-025 Glitch test: class_in toggles 00/01 every 2 cycles, and 11 is injected for 3 cycles -> class_stable never changes and pump_on stays 0.
REQ-026 enable=0 at cycle 3 of RUN -> pump_on=0 on the next edge, the full 32-cycle COOL follows, and timeout stays 0.
REQ-027 rst pulsed mid-RUN -> pump_on=0, run_count=0, state=IDLE after that edge; a DRY input then needs 5 edges to restart the pump.
